// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding,
// which matches the 2-bit y code the sequence detector also uses.
package seq_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } tx_state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register with asynchronous active-low clear.
// Load takes priority over shift.
module piso_shift #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts pattern/len/reps over valid/ready and
// shifts the pattern out MSB-first, with optional idle gaps between repeats.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter  int unsigned W     = 8,
  parameter  int unsigned REP_W = 4,
  parameter  int unsigned GAP   = 1,
  localparam int unsigned LW    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [W-1:0]     pattern,
  input  logic [LW-1:0]    len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [1:0]       y
);

  localparam int unsigned     GW       = $clog2(GAP + 2);
  localparam logic [GW-1:0]   GAP_INIT = (GAP > 0) ? GW'(GAP - 1) : '0;

  tx_state_e        state, state_nx;
  logic [W-1:0]     pat_q, aligned_in, sr_din;
  logic [LW-1:0]    len_q, bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             take, last_bit, more_reps, reload;
  logic             sr_load, sr_shift, sr_msb;

  // Left-align so pattern[len-1] lands in the shift register MSB.
  assign aligned_in = pattern << (LW'(W) - len);
  assign take       = (state == ST_IDLE) && start_valid && !abort;
  assign last_bit   = (bit_cnt == LW'(1));
  assign more_reps  = (rep_cnt > REP_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    reload   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take) state_nx = (len == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (last_bit) begin
          if (!more_reps) begin
            state_nx = ST_DONE;
          end else if (GAP > 0) begin
            state_nx = ST_GAP;
          end else begin
            reload = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (gap_cnt == '0) begin
          state_nx = ST_SEND;
          reload   = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign sr_load  = (take && (len != '0)) || reload;
  assign sr_din   = take ? aligned_in : pat_q;
  assign sr_shift = (state == ST_SEND) && !abort;

  piso_shift #(.W(W)) u_shift (
    .clk   (clk),
    .clr_n (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // Repeat count is consumed on each reload, whether back-to-back or after a gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (take) begin
        pat_q   <= aligned_in;
        len_q   <= len;
        bit_cnt <= len;
        rep_cnt <= (reps == '0) ? REP_W'(1) : reps;
      end else if (reload) begin
        bit_cnt <= len_q;
        rep_cnt <= rep_cnt - REP_W'(1);
      end else if (state == ST_SEND) begin
        bit_cnt <= bit_cnt - LW'(1);
      end

      if (state == ST_SEND) begin
        gap_cnt <= GAP_INIT;
      end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  always_comb begin
    y           = state;
    start_ready = (state == ST_IDLE);
    bit_valid   = (state == ST_SEND);
    bit_out     = (state == ST_SEND) && sr_msb;
    done        = (state == ST_DONE);
  end

endmodule
